// File: rtl/custom_axi_ip_apb_regif.sv
// APB3 register interface for the custom IP core: three write shadows, three status captures.
// Define CUSTOM_AXI_IP_REGIF_PSLVERR_EN to report pslverr on unmapped/read-only accesses.
module custom_axi_ip_apb_regif #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]           pwdata_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [DATA_WIDTH-1:0] reg2ip_data_o,
  output logic [2:0]            reg2ip_en_o,
  input  logic [DATA_WIDTH+2:0] ip2reg_data_i
);

  if (DATA_WIDTH != 96) begin : g_width_check
    $error("DATA_WIDTH must be 96");
  end

`ifdef CUSTOM_AXI_IP_REGIF_PSLVERR_EN
  localparam logic        ERR_EN   = 1'b1;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
`else
  localparam logic        ERR_EN   = 1'b0;
  localparam logic [31:0] ERR_DATA = 32'h0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    WR_STROBE,
    RD_DATA,
    DONE
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic        unmapped;
  logic        err_q;
  logic [31:0] shadow [3];
  logic [31:0] stat   [3];
  logic [2:0]  newf;

  logic        access;
  logic        addr_unmapped;
  logic        wr_ro;
  logic [2:0]  vld;
  logic [31:0] val [3];
  logic [2:0]  cap;
  logic [31:0] rd_data;
  logic        unused_ok;

  assign unused_ok = ^paddr_i[1:0];
  assign access = psel_i & penable_i;
  assign addr_unmapped = (paddr_i[ADDR_WIDTH-1:5] != '0) ||
                         (paddr_i[4:2] == 3'd7);
  assign wr_ro = pwrite_i & (paddr_i[4:2] >= 3'd3);
  assign reg2ip_data_o = {shadow[0], shadow[1], shadow[2]};

  // The core only refreshes its outputs while it is not being strobed.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      val[k] = ip2reg_data_i[98-33*k -: 32];
      vld[k] = ip2reg_data_i[66-33*k];
      cap[k] = vld[k] & (reg2ip_en_o == 3'b000);
    end
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      3'd0:    rd_data = shadow[0];
      3'd1:    rd_data = shadow[1];
      3'd2:    rd_data = shadow[2];
      3'd3:    rd_data = stat[0];
      3'd4:    rd_data = stat[1];
      3'd5:    rd_data = stat[2];
      3'd6:    rd_data = {29'b0, newf};
      default: rd_data = '0;
    endcase
    if (unmapped) rd_data = ERR_DATA;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      idx         <= '0;
      unmapped    <= 1'b0;
      err_q       <= 1'b0;
      newf        <= '0;
      prdata_o    <= '0;
      pready_o    <= 1'b0;
      pslverr_o   <= 1'b0;
      reg2ip_en_o <= '0;
      for (int k = 0; k < 3; k++) begin
        shadow[k] <= '0;
        stat[k]   <= '0;
      end
    end else begin
      reg2ip_en_o <= '0;
      pready_o    <= 1'b0;
      pslverr_o   <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (cap[k]) begin
          stat[k] <= val[k];
          newf[k] <= 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (access) begin
            idx      <= paddr_i[4:2];
            unmapped <= addr_unmapped;
            err_q    <= addr_unmapped | wr_ro;
            if (pwrite_i) begin
              state <= WR_STROBE;
              for (int k = 0; k < 3; k++) begin
                if (!addr_unmapped && paddr_i[4:2] == 3'(k)) begin
                  shadow[k]      <= pwdata_i;
                  reg2ip_en_o[k] <= 1'b1;
                end
              end
            end else begin
              state <= RD_DATA;
            end
          end
        end
        WR_STROBE: begin
          pready_o  <= 1'b1;
          pslverr_o <= ERR_EN & err_q;
          state     <= DONE;
        end
        RD_DATA: begin
          prdata_o  <= rd_data;
          pready_o  <= 1'b1;
          pslverr_o <= ERR_EN & err_q;
          // A same-cycle capture keeps the flag set.
          for (int k = 0; k < 3; k++) begin
            if (!unmapped && idx == 3'(k + 3) && !cap[k]) newf[k] <= 1'b0;
          end
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_custom_axi_ip_apb_regif.sv
// Directed bench for custom_axi_ip_apb_regif.
module tb_custom_axi_ip_apb_regif;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [95:0] r2i;
  logic [2:0]  en;
  logic [98:0] ip2reg = '0;

  int total = 0;
  int bad = 0;

  logic [31:0] rd;
  logic        err;
  int          lat;
  logic [2:0]  ens;

`ifdef CUSTOM_AXI_IP_REGIF_PSLVERR_EN
  localparam logic        EXP_ERR = 1'b1;
  localparam logic [31:0] EXP_BAD = 32'hDEADBEEF;
`else
  localparam logic        EXP_ERR = 1'b0;
  localparam logic [31:0] EXP_BAD = 32'h0;
`endif

  custom_axi_ip_apb_regif dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .psel_i(psel),
    .penable_i(penable),
    .pwrite_i(pwrite),
    .paddr_i(paddr),
    .pwdata_i(pwdata),
    .prdata_o(prdata),
    .pready_o(pready),
    .pslverr_o(pslverr),
    .reg2ip_data_o(r2i),
    .reg2ip_en_o(en),
    .ip2reg_data_i(ip2reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [11:0] a,
                      input logic [31:0] wd, input logic [98:0] ip_mid,
                      input logic [98:0] ip_end, output logic [31:0] r,
                      output logic e, output int l, output logic [2:0] es);
    psel = 1'b1; pwrite = w; paddr = a; pwdata = wd; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    l = 0; es = '0;
    @(negedge clk);
    l = 1; es |= en; ip2reg = ip_mid;
    @(negedge clk);
    l = 2; es |= en; ip2reg = ip_end;
    while (!pready && l < 8) begin
      @(negedge clk);
      l++; es |= en;
    end
    r = prdata; e = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_prdata", prdata, 0);
    check("rst_pready", pready, 0);
    check("rst_pslverr", pslverr, 0);
    check("rst_en", en, 0);
    check("rst_r2i", r2i, 0);
    rst_n = 1'b1;
    @(negedge clk);

    psel = 1'b1; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'hCAFE0001;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check("w1_r2i", r2i, {32'h0, 32'hCAFE0001, 32'h0});
    check("w1_en", en, 3'b010);
    check("w1_rdy0", pready, 0);
    @(negedge clk);
    check("w1_en_off", en, 0);
    check("w1_rdy", pready, 1);
    check("w1_err", pslverr, 0);
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("w1_rdy_off", pready, 0);

    ip2reg = {32'h2468, 1'b1, 32'h369C, 1'b1, 32'h48D0, 1'b1};
    repeat (2) @(negedge clk);
    xfer(0, 12'h018, 0, ip2reg, ip2reg, rd, err, lat, ens);
    check("new_all", rd, 32'h7);
    check("rd_lat", lat, 2);
    ip2reg = '0;
    @(negedge clk);
    xfer(0, 12'h00C, 0, '0, '0, rd, err, lat, ens);
    check("stat3", rd, 32'h2468);
    xfer(0, 12'h010, 0, '0, '0, rd, err, lat, ens);
    check("stat4", rd, 32'h369C);
    xfer(0, 12'h014, 0, '0, '0, rd, err, lat, ens);
    check("stat5", rd, 32'h48D0);
    xfer(0, 12'h018, 0, '0, '0, rd, err, lat, ens);
    check("new_clr", rd, 32'h0);
    xfer(0, 12'h004, 0, '0, '0, rd, err, lat, ens);
    check("sh1_rd", rd, 32'hCAFE0001);

    ip2reg = {32'h5555, 1'b1, 66'd0};
    @(negedge clk);
    ip2reg = '0;
    @(negedge clk);
    xfer(1, 12'h000, 32'h1, {32'hAAAA, 1'b1, 66'd0}, '0, rd, err, lat, ens);
    check("sup_en", ens, 3'b001);
    check("wr_lat", lat, 2);
    ip2reg = '0;
    xfer(0, 12'h00C, 0, '0, '0, rd, err, lat, ens);
    check("sup_keep", rd, 32'h5555);
    xfer(1, 12'h000, 32'h2, {32'hAAAA, 1'b1, 66'd0},
         {32'hAAAA, 1'b1, 66'd0}, rd, err, lat, ens);
    ip2reg = '0;
    xfer(0, 12'h00C, 0, '0, '0, rd, err, lat, ens);
    check("sup_take", rd, 32'hAAAA);
    check("sh_all", r2i, {32'h2, 32'hCAFE0001, 32'h0});

    ip2reg = {33'd0, 32'h1111, 1'b1, 33'd0};
    @(negedge clk);
    ip2reg = '0;
    @(negedge clk);
    xfer(0, 12'h010, 0, {33'd0, 32'h77, 1'b1, 33'd0}, '0, rd, err, lat, ens);
    check("race_old", rd, 32'h1111);
    xfer(0, 12'h018, 0, '0, '0, rd, err, lat, ens);
    check("race_new", rd, 32'h2);
    xfer(0, 12'h010, 0, '0, '0, rd, err, lat, ens);
    check("race_val", rd, 32'h77);
    xfer(0, 12'h018, 0, '0, '0, rd, err, lat, ens);
    check("race_clr", rd, 32'h0);

    xfer(1, 12'h01C, 32'h1234, '0, '0, rd, err, lat, ens);
    check("unm_w_en", ens, 0);
    check("unm_w_err", err, EXP_ERR);
    xfer(1, 12'h00C, 32'h1234, '0, '0, rd, err, lat, ens);
    check("ro_w_en", ens, 0);
    check("ro_w_err", err, EXP_ERR);
    check("ill_w_r2i", r2i, {32'h2, 32'hCAFE0001, 32'h0});
    xfer(0, 12'h020, 0, '0, '0, rd, err, lat, ens);
    check("unm_r_data", rd, EXP_BAD);
    check("unm_r_err", err, EXP_ERR);
    xfer(0, 12'h00C, 0, '0, '0, rd, err, lat, ens);
    check("ro_r_data", rd, 32'hAAAA);
    check("ro_r_err", err, 0);

    psel = 1'b1; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h99;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check("rs_en_on", en, 3'b100);
    #1 rst_n = 1'b0;
    #1;
    check("rs_en_off", en, 0);
    check("rs_r2i", r2i, 0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rs_quiet_en", en, 0);
      check("rs_quiet_rdy", pready, 0);
    end
    xfer(0, 12'h008, 0, '0, '0, rd, err, lat, ens);
    check("rs_sh2", rd, 0);
    xfer(1, 12'h008, 32'h55, '0, '0, rd, err, lat, ens);
    check("rs_w_en", ens, 3'b100);
    check("rs_w_lat", lat, 2);
    check("rs_w_r2i", r2i, {64'h0, 32'h55});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
